// File: rtl/jk_pkg.sv
// Shared {j,k} mode encodings for the JK flip-flop bank and its bench.
// Combinational constants only; no latency; no flow control.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with a parameterised synchronous reset value.
// Latency: one clk; no backpressure, j/k sampled every rising edge.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    // Reset is sampled on the edge only, so it overrides whatever mode is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_flipflop.sv
// Bank of WIDTH independent JK flip-flops with complementary outputs.
// Latency: one clk; no backpressure, inputs sampled every rising edge.
module jk_flipflop
    import jk_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i])
        );
    end

    // Derived from q rather than registered, so q and qn can never agree.
    assign qn = ~q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Scoreboarded bench for a 4-bit JK bank with a mixed reset value.
module tb_jk_flipflop;
    import jk_pkg::*;

    localparam int             W  = 4;
    localparam logic [W-1:0]   RV = 4'b0011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [W-1:0] qn;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_queue[$];
    logic [W-1:0] model_q;
    bit           model_valid = 1'b0;
    logic [W-1:0] exp_e;

    always #5 clk = ~clk;

    jk_flipflop #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (j),
        .k     (k),
        .q     (q),
        .qn    (qn)
    );

    // One clock edge: glitch inputs early in the low phase, settle them, then
    // advance the reference model (characteristic equation q+ = j&~q | ~k&q).
    task automatic step(input logic r, input logic [W-1:0] jj, input logic [W-1:0] kk);
        @(negedge clk);
        rst_n = 1'($urandom);
        j     = W'($urandom);
        k     = W'($urandom);
        #2;
        if (model_valid) begin
            checks++;
            if (q !== model_q) begin
                errors++;
                $display("FAIL mid_cycle_stable: q=%b expected %b", q, model_q);
            end
        end
        rst_n = r;
        j     = jj;
        k     = kk;
        @(posedge clk);
        if (!r) begin
            model_q     = RV;
            model_valid = 1'b1;
        end else begin
            model_q = (jj & ~model_q) | (~kk & model_q);
        end
        if (model_valid) exp_queue.push_back(model_q);
    endtask

    task automatic mode_steps(input logic [1:0] m, input int n);
        logic [W-1:0] jj;
        logic [W-1:0] kk;
        jj = {W{m[1]}};
        kk = {W{m[0]}};
        for (int i = 0; i < n; i++) step(1'b1, jj, kk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_queue.size() > 0) begin
            exp_e = exp_queue.pop_front();
            checks++;
            if (q !== exp_e || qn !== ~exp_e) begin
                errors++;
                $display("FAIL edge_result: q=%b qn=%b expected q=%b qn=%b", q, qn, exp_e, ~exp_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] sweep [5];
        rst_n = 1'b1;
        j     = '0;
        k     = '0;
        sweep[0] = JK_HOLD;
        sweep[1] = JK_RESET;
        sweep[2] = JK_SET;
        sweep[3] = JK_TOGGLE;
        sweep[4] = JK_HOLD;

        // Reset held two edges with j=k=1
        step(1'b0, '1, '1);
        step(1'b0, '1, '1);

        // Mode sweep, three edges per mode
        for (int i = 0; i < 5; i++) mode_steps(sweep[i], 3);

        // Clear, then eight toggle edges as a clk/2 divider
        mode_steps(JK_RESET, 1);
        mode_steps(JK_TOGGLE, 8);

        // Reset lands mid-toggle, toggling resumes from the reset value
        mode_steps(JK_TOGGLE, 3);
        step(1'b0, '1, '1);
        mode_steps(JK_TOGGLE, 3);

        // Reset released on an edge that also presents toggle
        step(1'b0, '0, '0);
        step(1'b1, '1, '1);

        // Per-bit mixed modes applied twice from zero
        mode_steps(JK_RESET, 1);
        step(1'b1, 4'b1010, 4'b0110);
        step(1'b1, 4'b1010, 4'b0110);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) != 0), W'($urandom), W'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_queue.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_queue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
